// File: rtl/gun_turret_pkg.sv
// Shared game definitions: sprite FSM encoding and default screen geometry.
package gun_turret_pkg;

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_FIRE  = 2'd1,
    ST_COOL  = 2'd2
  } turret_state_t;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;
  localparam int GUN_W_DEF    = 94;
  localparam int GUN_H_DEF    = 14;
  localparam int GUN_Y_DEF    = 466;

  // Left edge that centres a sprite of width w on a screen of width screen_w.
  function automatic logic [9:0] center_x(input int screen_w, input int w);
    return 10'((screen_w - w) / 2);
  endfunction

endpackage

// File: rtl/gun_turret_window.sv
// Registered rectangle hit-test: o_draw is high one cycle after the raster
// position falls inside [i_x0, i_x0+W-1] x [i_y0, i_y0+H-1].
module sprite_window #(
  parameter int W = 94,
  parameter int H = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] i_hcount,
  input  logic [9:0] i_vcount,
  input  logic [9:0] i_x0,
  input  logic [9:0] i_y0,
  output logic       o_draw
);

  logic [10:0] w_x_end;
  logic [10:0] w_y_end;
  logic        w_hit;

  // 11-bit right/bottom edges so a window touching the 10-bit limit cannot wrap.
  always_comb begin
    w_x_end = {1'b0, i_x0} + 11'(W - 1);
    w_y_end = {1'b0, i_y0} + 11'(H - 1);
    w_hit   = (i_hcount >= i_x0) && ({1'b0, i_hcount} <= w_x_end) &&
              (i_vcount >= i_y0) && ({1'b0, i_vcount} <= w_y_end);
  end

  // Register the hit to give a clean one-cycle pixel pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) o_draw <= 1'b0;
    else       o_draw <= w_hit;
  end

endmodule

// File: rtl/gun_turret.sv
// Player gun sprite: frame-rate movement with edge clamping, edge-triggered
// firing with cooldown, and a short muzzle-flash colour after each shot.
module gun_turret
  import gun_turret_pkg::*;
#(
  parameter int         SCREEN_W     = SCREEN_W_DEF,
  parameter int         GUN_W        = GUN_W_DEF,
  parameter int         GUN_H        = GUN_H_DEF,
  parameter int         GUN_Y        = GUN_Y_DEF,
  parameter int         STEP         = 2,
  parameter int         COOLDOWN     = 30,
  parameter int         FLASH_FRAMES = 4,
  parameter logic [5:0] COLOR        = 6'h00,
  parameter logic [5:0] FLASH_COLOR  = 6'h3F
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       frame_tick,
  input  logic       izq,
  input  logic       der,
  input  logic       fire,
  output logic [5:0] data,
  output logic       draw,
  output logic       shot,
  output logic [9:0] shot_x,
  output logic       ready
);

  localparam int          CW    = $clog2(COOLDOWN + 2);
  localparam int          FW    = $clog2(FLASH_FRAMES + 2);
  localparam logic [10:0] MAX_X = 11'(SCREEN_W - GUN_W);

  turret_state_t r_state, w_state_nxt;
  logic [9:0]    r_pos_x, w_pos_nxt;
  logic [9:0]    w_pos_dn;
  logic [10:0]   w_pos_up;
  logic [CW-1:0] r_cool;
  logic [FW-1:0] r_flash;
  logic          r_fire_lo;  // fire was sampled low last cycle; 0 after reset
  logic          w_fire_edge;
  logic          w_draw;

  // Clamped next position; left move checked before subtracting so it never wraps.
  always_comb begin
    w_pos_dn = r_pos_x - 10'(STEP);
    w_pos_up = {1'b0, r_pos_x} + 11'(STEP);
    if (izq) w_pos_nxt = ({1'b0, r_pos_x} < 11'(STEP)) ? 10'd0 : w_pos_dn;
    else     w_pos_nxt = (w_pos_up > MAX_X) ? MAX_X[9:0] : w_pos_up[9:0];
  end

  // Position only moves on a frame tick with exactly one direction held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     r_pos_x <= center_x(SCREEN_W, GUN_W);
    else if (frame_tick && (izq ^ der)) r_pos_x <= w_pos_nxt;
  end

  // Fire history: reset as "not low" so a trigger held through reset is not an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_fire_lo <= 1'b0;
    else       r_fire_lo <= ~fire;
  end

  assign w_fire_edge = fire & r_fire_lo;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_READY;
    else       r_state <= w_state_nxt;
  end

  // FSM next state; edges seen outside READY are simply dropped.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_READY: if (w_fire_edge) w_state_nxt = ST_FIRE;
      ST_FIRE:  w_state_nxt = ST_COOL;
      ST_COOL:  if (r_cool == '0) w_state_nxt = ST_READY;
      default:  w_state_nxt = ST_READY;
    endcase
  end

  // Cooldown and flash counters: loaded on the shot, saturating frame countdown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cool  <= '0;
      r_flash <= '0;
    end else if (r_state == ST_FIRE) begin
      r_cool  <= CW'(COOLDOWN);
      r_flash <= FW'(FLASH_FRAMES);
    end else if (frame_tick) begin
      if (r_cool  != '0) r_cool  <= r_cool - 1'b1;
      if (r_flash != '0) r_flash <= r_flash - 1'b1;
    end
  end

  // Muzzle x uses the pre-move position of the FIRE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  shot_x <= '0;
    else if (r_state == ST_FIRE) shot_x <= r_pos_x + 10'(GUN_W / 2);
  end

  sprite_window #(.W(GUN_W), .H(GUN_H)) u_win (
    .clk      (clk),
    .reset    (reset),
    .i_hcount (hcount),
    .i_vcount (vcount),
    .i_x0     (r_pos_x),
    .i_y0     (10'(GUN_Y)),
    .o_draw   (w_draw)
  );

  assign draw  = w_draw;
  assign data  = w_draw ? ((r_flash != '0) ? FLASH_COLOR : COLOR) : 6'h00;
  assign ready = (r_state == ST_READY);
  assign shot  = (r_state == ST_FIRE);

endmodule

// File: doc/gun_turret.md
GUN_TURRET -- requirements
Module: gun_turret

Interface
REQ-001 Parameter SCREEN_W, 640, visible width in pixels.
REQ-002 Parameter GUN_W, 94, sprite width in pixels.
REQ-003 Parameter GUN_H, 14, sprite height in lines.
REQ-004 Parameter GUN_Y, 466, first sprite line.
REQ-005 Parameter STEP, 2, pixels moved per frame_tick.
REQ-006 Parameter COOLDOWN, 30, frame_ticks from a shot until re-armed.
REQ-007 Parameter FLASH_FRAMES, 4, frame_ticks the muzzle-flash colour is shown after a shot.
REQ-008 Parameter COLOR, 6'h00, normal sprite colour; parameter FLASH_COLOR, 6'h3F, flash colour.
REQ-009 Port clk, input, 1, single system clock; all logic is on its rising edge.
REQ-010 Port reset, input, 1, asynchronous active-high reset.
REQ-011 Ports hcount and vcount, input, 10 each, current raster pixel and line.
REQ-012 Port frame_tick, input, 1, one-cycle pulse once per frame.
REQ-013 Ports izq and der, input, 1 each, move-left and move-right levels.
REQ-014 Port fire, input, 1, trigger level, synchronous to clk.
REQ-015 Port data, output, 6, pixel colour; port draw, output, 1, pixel-valid.
REQ-016 Port shot, output, 1, one-cycle shot pulse; port shot_x, output, 10, muzzle x of the last shot.
REQ-017 Port ready, output, 1, high while armed.

Function
REQ-018 Position register pos_x (10 bit, sprite left edge) SHALL change only in cycles where frame_tick is high.
REQ-019 On frame_tick: izq only -> pos_x = max(pos_x-STEP, 0); der only -> pos_x = min(pos_x+STEP, SCREEN_W-GUN_W); both or neither -> unchanged.
REQ-020 Clamping SHALL use arithmetic at least 11 bits wide, with no unsigned wrap below 0.
REQ-021 draw SHALL be registered (1-cycle latency) and high iff GUN_Y <= vcount <= GUN_Y+GUN_H-1 and pos_x <= hcount <= pos_x+GUN_W-1.
REQ-022 data SHALL be FLASH_COLOR while drawing during the flash window, COLOR while drawing otherwise, and 0 when draw is low.
REQ-023 The FSM SHALL have states READY, FIRE, COOL.
REQ-024 READY: on a fire rising edge (fire high, previous-cycle fire low) go to FIRE.
REQ-025 FIRE lasts exactly one cycle: shot=1, shot_x = pos_x + GUN_W/2 is latched, cooldown counter = COOLDOWN, flash counter = FLASH_FRAMES, next state COOL.
REQ-026 COOL: each frame_tick decrements both counters, saturating at 0; when the cooldown counter reaches 0 go to READY on the following cycle.
REQ-027 Fire edges in FIRE or COOL SHALL be discarded, not queued; a fire level held through re-arm SHALL NOT fire.
REQ-028 ready = 1 only in READY; flash window = flash counter nonzero.
REQ-029 A movement frame_tick coincident with FIRE SHALL apply, with shot_x taken from the pre-update pos_x.
REQ-030 COOLDOWN=0 SHALL give READY -> FIRE -> COOL -> READY without waiting for a frame_tick.

Reset
REQ-031 Reset SHALL force pos_x=(SCREEN_W-GUN_W)/2, state READY, counters 0, fire history 0, draw 0, data 0, shot 0, and shot_x 0, including when asserted in mid-cooldown.
REQ-032 Reset SHALL leave no sticky fire edge: fire held high across deassertion SHALL NOT shoot.

Structure
REQ-033 The FSM state encoding and the default screen-geometry constants SHALL live in a shared game package that other sprite blocks can reuse.
REQ-034 A sub-module sprite_window (a registered rectangle hit-test on hcount/vcount) is natural and SHALL be reusable by the duck sprites.

Verification
REQ-035 After reset with defaults -> pos_x=273, ready=1, and draw is high exactly for hcount 273..366 and vcount 466..479 (1-cycle delayed).
REQ-036 izq held for 200 frame_ticks -> pos_x reaches 0 and stays there; der held for 400 -> pos_x is 546 and stays there; both held -> no change.
REQ-037 Fire edge at pos_x=100 -> one shot pulse, shot_x=147, ready=0, data=6'h3F on drawn pixels for 4 frame_ticks, ready=1 after 30 frame_ticks.
REQ-038 Fire toggled every frame during cooldown -> exactly one shot; fire held high through re-arm -> no second shot until a fresh edge.
REQ-039 Reset asserted at cooldown count 10 -> immediate ready=1 and pos_x=273; fire high across reset release -> shot stays 0.
REQ-040 frame_tick with der coincident with the FIRE cycle at pos_x=200 -> shot_x=247 and pos_x=202.
